// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes: FIPS-197 inverse S-box on all 16 bytes, 1-cycle registered output, no backpressure.
// Define INV_SUB_BYTES_PIPE2_EN to split inverse-affine and GF(2^8) inverse into two stages (2-cycle latency).
module inv_sub_bytes (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] in,
  output logic         out_valid,
  output logic [127:0] out
);

  // Multiply in GF(2^8) reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  logic         out_valid_d, out_valid_q;
  logic [127:0] out_d, out_q;

`ifdef INV_SUB_BYTES_PIPE2_EN
  logic         stg_valid_d, stg_valid_q;
  logic [127:0] stg_d, stg_q;

  always_comb begin
    stg_valid_d = in_valid;
    stg_d       = stg_q;
    if (in_valid) begin
      for (int i = 0; i < 16; i++) stg_d[8*i +: 8] = inv_affine(in[8*i +: 8]);
    end
    out_valid_d = stg_valid_q;
    out_d       = out_q;
    if (stg_valid_q) begin
      for (int i = 0; i < 16; i++) out_d[8*i +: 8] = gf_inv(stg_q[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid_q <= 1'b0;
      stg_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_q       <= stg_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end
`else
  // Holding on idle cycles keeps X on an unqualified input out of the register.
  always_comb begin
    out_valid_d = in_valid;
    out_d       = out_q;
    if (in_valid) begin
      for (int i = 0; i < 16; i++) out_d[8*i +: 8] = gf_inv(inv_affine(in[8*i +: 8]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes; reference inverse S-box is derived from the forward S-box definition.
module tb_inv_sub_bytes;

`ifdef INV_SUB_BYTES_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in = '0;
  logic         out_valid;
  logic [127:0] out;

  inv_sub_bytes dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic         vq [$];
  logic [127:0] dq [$];
  logic [127:0] got [$];
  logic         exp_vld;
  logic [127:0] exp_out;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int x   = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x * 2;
      if (x > 255) x = x ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = isbox[d[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, compare at next negedge against the delayed-input model.
  task automatic cycle(input logic v, input logic [127:0] d);
    logic         ev;
    logic [127:0] ed;
    in_valid = v;
    in       = d;
    @(posedge clk);
    @(negedge clk);
    vq.push_back(v);
    dq.push_back(d);
    if (vq.size() == LAT) begin
      ev = vq.pop_front();
      ed = dq.pop_front();
      exp_vld = ev;
      if (ev) exp_out = ref_state(ed);
    end else begin
      exp_vld = 1'b0;
    end
    chk("out_valid", {127'b0, out_valid}, {127'b0, exp_vld});
    chk("out", out, exp_out);
    if (out_valid) got.push_back(out);
  endtask

  task automatic reset_mid(input logic v, input logic [127:0] d);
    in_valid = v;
    in       = d;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_vld", {127'b0, out_valid}, 128'h0);
    chk("rst_async_out", out, 128'h0);
    vq.delete();
    dq.delete();
    exp_vld = 1'b0;
    exp_out = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_vld", {127'b0, out_valid}, 128'h0);
    chk("rst_hold_out", out, 128'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0]   inv_x;
    logic [7:0]   s;
    logic [127:0] d;

    for (int x = 0; x < 256; x++) begin
      inv_x = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv_x = 8'(y);
      s = inv_x ^ rotl(inv_x, 1) ^ rotl(inv_x, 2) ^ rotl(inv_x, 3) ^ rotl(inv_x, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
    exp_vld = 1'b0;
    exp_out = '0;

    @(negedge clk);
    reset_mid(1'b0, '0);
    cycle(1'b0, 'x);
    cycle(1'b0, 'x);

    // Single vector, then idle: result appears after LAT edges and is then held.
    got.delete();
    cycle(1'b1, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    for (int k = 1; k < LAT; k++) cycle(1'b0, 'x);
    cycle(1'b0, 'x);
    cycle(1'b0, 'x);
    chk("vec7a_count", 128'(got.size()), 128'd1);
    if (got.size() > 0) chk("vec7a_out", got[got.size()-1], 128'hbdb52189f261b63d0b107c9e8b6e776e);
    chk("vec7a_hold", out, 128'hbdb52189f261b63d0b107c9e8b6e776e);

    // Back-to-back 00 then 63 lanes.
    got.delete();
    cycle(1'b1, 128'h0);
    cycle(1'b1, {16{8'h63}});
    for (int k = 0; k < LAT; k++) cycle(1'b0, 'x);
    chk("b2b_count", 128'(got.size()), 128'd2);
    if (got.size() == 2) begin
      chk("b2b_first", got[0], {16{8'h52}});
      chk("b2b_second", got[1], 128'h0);
    end

    // Mixed anchor bytes in distinct lanes.
    got.delete();
    cycle(1'b1, 128'h00_01_52_63_7a_7c_ed_ff_ff_ed_7c_7a_63_52_01_00);
    for (int k = 0; k < LAT; k++) cycle(1'b0, 'x);
    if (got.size() > 0) chk("anchors", got[0], 128'h52_09_48_00_bd_01_53_7d_7d_53_01_bd_00_48_09_52);

    // Full 256-value sweep, every lane carrying Sbox(x).
    got.delete();
    for (int x = 0; x < 256; x++) cycle(1'b1, {16{sbox[x]}});
    for (int k = 0; k < LAT; k++) cycle(1'b0, 'x);
    chk("sweep_count", 128'(got.size()), 128'd256);
    for (int x = 0; x < 256 && x < got.size(); x += 51) chk("sweep_lane", got[x], {16{8'(x)}});

    // Random traffic with random idle gaps; idle data is garbage that must not leak.
    for (int k = 0; k < 64; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 3) != 0, d);
    end

    // Four-state stream with reset landing during the third.
    got.delete();
    cycle(1'b1, {$urandom, $urandom, $urandom, $urandom});
    cycle(1'b1, {$urandom, $urandom, $urandom, $urandom});
    reset_mid(1'b1, {$urandom, $urandom, $urandom, $urandom});
    cycle(1'b0, 'x);
    cycle(1'b0, 'x);
    chk("mid_rst_count", 128'(got.size()), 128'(3 - LAT));
    cycle(1'b1, {$urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < LAT; k++) cycle(1'b0, 'x);
    chk("post_rst_count", 128'(got.size()), 128'(4 - LAT));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
